// File: rtl/mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam int MDU_XLEN_DEFAULT = 32;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // MULT and DIV are the signed flavours (even encodings).
  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide unit (slave).
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  import mdu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  mdu_op_e         in_op;
  logic [XLEN-1:0] in_x;
  logic [XLEN-1:0] in_y;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_hi;
  logic [XLEN-1:0] out_lo;
  logic            busy;

  modport master (
    output in_valid, in_op, in_x, in_y, flush, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, busy
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, flush, out_ready,
    output in_ready, out_valid, out_hi, out_lo, busy
  );

endinterface

// File: rtl/mdu_div_core.sv
// Iterative restoring divider, one quotient bit per cycle plus a sign-fix cycle.
// Build option MDU_DIV_EARLY_EXIT_EN: skip the iterations for divide-by-zero or |x| < |y|.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            is_signed,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  localparam int            CW      = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_END = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE   = {{(XLEN-1){1'b0}}, 1'b1};

  logic            running_r;
  logic            early_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] div_r;
  logic [XLEN-1:0] x_r;
  logic            dz_r;
  logic            neg_q_r;
  logic            neg_r_r;

  logic [XLEN-1:0] xa_s;
  logic [XLEN-1:0] ya_s;
  logic            early_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] step_rem_s;
  logic [XLEN-1:0] step_quo_s;

  assign xa_s = (is_signed && x[XLEN-1]) ? (~x + ONE) : x;
  assign ya_s = (is_signed && y[XLEN-1]) ? (~y + ONE) : y;

`ifdef MDU_DIV_EARLY_EXIT_EN
  assign early_s = (y == {XLEN{1'b0}}) || (xa_s < ya_s);
`else
  assign early_s = 1'b0;
`endif

  assign done = running_r && (cnt_r == CNT_END);

  // One restoring step: the dividend bits shift out of quo_r as quotient bits shift in.
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, div_r};
    if (!diff_s[XLEN]) begin
      step_rem_s = diff_s[XLEN-1:0];
      step_quo_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      step_rem_s = shifted_s[XLEN-1:0];
      step_quo_s = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  // Divider datapath and iteration counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running_r <= 1'b0;
      early_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      div_r     <= {XLEN{1'b0}};
      x_r       <= {XLEN{1'b0}};
      dz_r      <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else if (abort) begin
      running_r <= 1'b0;
    end else if (start) begin
      running_r <= 1'b1;
      early_r   <= early_s;
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      quo_r     <= xa_s;
      div_r     <= ya_s;
      x_r       <= x;
      dz_r      <= (y == {XLEN{1'b0}});
      neg_q_r   <= is_signed && (x[XLEN-1] ^ y[XLEN-1]);
      neg_r_r   <= is_signed && x[XLEN-1];
    end else if (running_r) begin
      if (done) begin
        running_r <= 1'b0;
      end else if (early_r) begin
        cnt_r <= CNT_END;
        rem_r <= quo_r;
        quo_r <= {XLEN{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
        rem_r <= step_rem_s;
        quo_r <= step_quo_s;
      end
    end
  end

  // Sign fix; divide-by-zero overrides the iterated result.
  always_comb begin
    q = quo_r;
    r = rem_r;
    if (dz_r) begin
      q = {XLEN{1'b1}};
      r = x_r;
    end else begin
      if (neg_q_r) begin
        q = ~quo_r + ONE;
      end else begin
        q = quo_r;
      end
      if (neg_r_r) begin
        r = ~rem_r + ONE;
      end else begin
        r = rem_r;
      end
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: one op in flight, valid/ready on both sides, flushable at any point.
// Build option MDU_DIV_EARLY_EXIT_EN (in mdu_div_core): short-cut trivial divides to 2 cycles.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN       = MDU_XLEN_DEFAULT,
  parameter int MUL_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  ex_mdu_if.slave    mdu
);

  localparam int             MCW      = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_STAGES - 1);
  localparam logic [MCW-1:0] MUL_ONE  = {{(MCW-1){1'b0}}, 1'b1};

  mdu_state_e        state_r;
  mdu_state_e        state_s;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   out_hi_r;
  logic [XLEN-1:0]   out_lo_r;
  logic [MCW-1:0]    mul_cnt_r;
  logic [2*XLEN-1:0] mul_pipe_r [MUL_STAGES];

  logic              accept_s;
  logic              div_start_s;
  logic              div_done_s;
  logic [XLEN-1:0]   div_q_s;
  logic [XLEN-1:0]   div_r_s;
  logic [2*XLEN-1:0] ext_x_s;
  logic [2*XLEN-1:0] ext_y_s;
  logic [2*XLEN-1:0] prod_s;

  assign accept_s    = mdu.in_valid && (state_r == IDLE) && !mdu.flush;
  assign div_start_s = accept_s && op_is_div(mdu.in_op);

  // Extending both operands to 2*XLEN makes one unsigned multiply serve MULT and MULTU.
  always_comb begin
    if (op_is_signed(mdu.in_op)) begin
      ext_x_s = {{XLEN{mdu.in_x[XLEN-1]}}, mdu.in_x};
      ext_y_s = {{XLEN{mdu.in_y[XLEN-1]}}, mdu.in_y};
    end else begin
      ext_x_s = {{XLEN{1'b0}}, mdu.in_x};
      ext_y_s = {{XLEN{1'b0}}, mdu.in_y};
    end
    prod_s = ext_x_s * ext_y_s;
  end

  // Next state; flush dominates every state.
  always_comb begin
    state_s = state_r;
    if (mdu.flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = op_is_div(mdu.in_op) ? DIV : MUL;
          end else begin
            state_s = IDLE;
          end
        end
        MUL: begin
          if (mul_cnt_r == MUL_LAST) begin
            state_s = DONE;
          end else begin
            state_s = MUL;
          end
        end
        DIV: begin
          if (div_done_s) begin
            state_s = DONE;
          end else begin
            state_s = DIV;
          end
        end
        DONE: begin
          if (mdu.out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, registered handshake outputs and result capture on entry to DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_hi_r    <= {XLEN{1'b0}};
      out_lo_r    <= {XLEN{1'b0}};
      mul_cnt_r   <= {MCW{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == DONE);
      if ((state_r == MUL) && (state_s == DONE)) begin
        {out_hi_r, out_lo_r} <= mul_pipe_r[MUL_STAGES-1];
      end else if ((state_r == DIV) && (state_s == DONE)) begin
        out_hi_r <= div_r_s;
        out_lo_r <= div_q_s;
      end
      if (accept_s) begin
        mul_cnt_r <= {MCW{1'b0}};
      end else if ((state_r == MUL) && (mul_cnt_r != MUL_LAST)) begin
        mul_cnt_r <= mul_cnt_r + MUL_ONE;
      end
    end
  end

  // Product pipe: stage 0 loads on accept, the last stage is read on entry to DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_pipe_r[i] <= {(2*XLEN){1'b0}};
      end
    end else begin
      if (accept_s) begin
        mul_pipe_r[0] <= prod_s;
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_pipe_r[i] <= mul_pipe_r[i-1];
      end
    end
  end

  mdu_div_core #(
    .XLEN (XLEN)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start_s),
    .abort     (mdu.flush),
    .x         (mdu.in_x),
    .y         (mdu.in_y),
    .is_signed (op_is_signed(mdu.in_op)),
    .done      (div_done_s),
    .q         (div_q_s),
    .r         (div_r_s)
  );

  assign mdu.in_ready  = in_ready_r;
  assign mdu.busy      = busy_r;
  assign mdu.out_valid = out_valid_r;
  assign mdu.out_hi    = out_hi_r;
  assign mdu.out_lo    = out_lo_r;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: driver pushes reference results, monitor pops and compares.
module tb_ex_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(XLEN)) bus ();

  ex_mdu #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mdu    (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic longint mag(input logic [31:0] v, input bit sgn);
    if (sgn && v[31]) return 64'h1_0000_0000 - longint'({32'h0, v});
    return longint'({32'h0, v});
  endfunction

  // Reference: plain arithmetic on the architectural definition of each op.
  function automatic exp_t ref_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      p;
    logic [63:0] u;
    int          sx, sy, sq, sr;
    bit          sgn;
    e.hold = 0;
    e.acc  = 0;
    sgn    = (op == 2'd2);
    if (op == 2'd0) begin
      sx = x; sy = y;
      p  = longint'(sx) * longint'(sy);
      e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 2;
    end else if (op == 2'd1) begin
      u  = {32'h0, x} * {32'h0, y};
      e.hi = u[63:32]; e.lo = u[31:0]; e.lat = 2;
    end else begin
      e.lat = 33;
      if (y == 32'h0) begin
        e.lo = 32'hFFFF_FFFF; e.hi = x;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'h0;
      end else if (sgn) begin
        sx = x; sy = y; sq = sx / sy; sr = sx % sy;
        e.lo = sq; e.hi = sr;
      end else begin
        e.lo = x / y; e.hi = x % y;
      end
`ifdef MDU_DIV_EARLY_EXIT_EN
      if (y == 32'h0 || mag(x, sgn) < mag(y, sgn)) e.lat = 2;
`endif
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready && waited < 300) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_op    = mdu_op_e'(2'($urandom_range(0, 3)));
      bus.in_x     = $urandom;
      bus.in_y     = $urandom;
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++; fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, required 1", waited);
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = mdu_op_e'(op);
    bus.in_x     = x;
    bus.in_y     = y;
    e      = ref_op(op, x, y);
    e.acc  = cyc + 1;
    e.hold = (hold >= 0) ? hold : $urandom_range(0, 3);
    sbq.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(1, 20));
      4: begin v = 32'($urandom_range(1, 20)); v = ~v + 32'd1; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor/consumer: compares every cycle out_valid is high, consumes after the entry's hold.
  initial begin
    bit   prev_v = 1'b0;
    int   hold = 0;
    exp_t e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_v = 1'b0; hold = 0; bus.out_ready = 1'b0;
      end else if (bus.out_valid) begin
        chk("busy_in_done", 64'(bus.busy), 64'd1);
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_output: got hi=%h lo=%h, required no output", bus.out_hi, bus.out_lo);
          bus.out_ready = 1'b1;
        end else begin
          e = sbq[0];
          if (!prev_v) begin
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            hold = e.hold;
          end
          chk("hi", 64'(bus.out_hi), 64'(e.hi));
          chk("lo", 64'(bus.out_lo), 64'(e.lo));
          if (hold == 0) begin
            bus.out_ready = 1'b1;
            void'(sbq.pop_front());
          end else begin
            hold--;
            bus.out_ready = 1'b0;
          end
        end
        prev_v = 1'b1;
      end else begin
        prev_v = 1'b0;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_op    = OP_MULT;
    bus.in_x     = 32'h0;
    bus.in_y     = 32'h0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_hi", 64'(bus.out_hi), 64'd0);
    chk("reset_lo", 64'(bus.out_lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    resetn = 1'b1;

    issue(2'd0, 32'hFFFF_FFFE, 32'd3, -1);
    issue(2'd1, 32'hFFFF_FFFE, 32'd3, -1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    issue(2'd3, 32'd100, 32'd7, 5);
    issue(2'd3, 32'd5, 32'd0, -1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    issue(2'd2, 32'hFFFF_FFFB, 32'd0, -1);
    issue(2'd2, 32'd3, 32'hFFFF_FFF9, -1);
    issue(2'd2, 32'hFFFF_FFFD, 32'd7, -1);

    // Flush a divide mid-iteration, with a competing request in the same cycle.
    issue(2'd2, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MULTU;
    bus.in_x     = 32'd9;
    bus.in_y     = 32'd9;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    void'(sbq.pop_back());
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    issue(2'd0, 32'd6, 32'd7, -1);

    // Asynchronous reset in the middle of a divide.
    issue(2'd3, 32'hDEAD_BEEF, 32'd13, 0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    sbq.delete();
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_hi", 64'(bus.out_hi), 64'd0);
    chk("midreset_lo", 64'(bus.out_lo), 64'd0);
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), -1);
    end

    w = 0;
    while (sbq.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sbq.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
